// File: rtl/game_sequencer.sv
// Per-frame game controller: runs the player/enemy/bullet update handshakes once
// per frame, resolves collisions, and owns lives, score, respawn delay and game-over.
module game_sequencer #(
  parameter int unsigned LIVES_INIT     = 3,
  parameter int unsigned RESPAWN_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       restart,
  input  logic       frame_tick,
  output logic       player_req,
  input  logic       player_done,
  output logic       enemy_req,
  input  logic       enemy_done,
  output logic       bullet_req,
  input  logic       bullet_done,
  input  logic       hit_player,
  input  logic       hit_enemy,
  output logic       respawn,
  output logic       enemy_respawn,
  output logic [2:0] life,
  output logic [7:0] score,
  output logic       game_over,
  output logic       frame_overrun,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WAIT_FRAME = 3'd1;
  localparam logic [2:0] S_UPD_PLAYER = 3'd2;
  localparam logic [2:0] S_UPD_ENEMY  = 3'd3;
  localparam logic [2:0] S_UPD_BULLET = 3'd4;
  localparam logic [2:0] S_CHECK      = 3'd5;
  localparam logic [2:0] S_RESPAWN    = 3'd6;
  localparam logic [2:0] S_GAME_OVER  = 3'd7;

  localparam logic [2:0] LIFE_INIT    = 3'(LIVES_INIT);
  localparam logic [7:0] RESPAWN_INIT = 8'(RESPAWN_FRAMES);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  logic [2:0] state_q, state_d;
  logic       player_req_q, player_req_d;
  logic       enemy_req_q, enemy_req_d;
  logic       bullet_req_q, bullet_req_d;
  logic       respawn_q, respawn_d;
  logic       enemy_respawn_q, enemy_respawn_d;
  logic [2:0] life_q, life_d;
  logic [7:0] score_q, score_d;
  logic       game_over_q, game_over_d;
  logic       overrun_q, overrun_d;
  logic [7:0] cnt_q, cnt_d;
  logic       busy_s;

  // A tick landing mid-update is dropped; remember that it happened
  assign busy_s    = (state_q == S_UPD_PLAYER) || (state_q == S_UPD_ENEMY) ||
                     (state_q == S_UPD_BULLET) || (state_q == S_CHECK);
  assign overrun_d = overrun_q | (frame_tick & busy_s);

  // Next-state and next-output logic
  always_comb begin
    state_d         = state_q;
    player_req_d    = player_req_q;
    enemy_req_d     = enemy_req_q;
    bullet_req_d    = bullet_req_q;
    respawn_d       = 1'b0;
    enemy_respawn_d = 1'b0;
    life_d          = life_q;
    score_d         = score_q;
    game_over_d     = game_over_q;
    cnt_d           = cnt_q;
    case (state_q)
      S_IDLE: begin
        life_d  = LIFE_INIT;
        score_d = 8'd0;
        if (start) begin
          respawn_d = 1'b1;
          state_d   = S_WAIT_FRAME;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_FRAME: begin
        if (frame_tick) begin
          player_req_d = 1'b1;
          state_d      = S_UPD_PLAYER;
        end else begin
          state_d = S_WAIT_FRAME;
        end
      end
      S_UPD_PLAYER: begin
        if (player_req_q && player_done) begin
          player_req_d = 1'b0;
          enemy_req_d  = 1'b1;
          state_d      = S_UPD_ENEMY;
        end else begin
          state_d = S_UPD_PLAYER;
        end
      end
      S_UPD_ENEMY: begin
        if (enemy_req_q && enemy_done) begin
          enemy_req_d  = 1'b0;
          bullet_req_d = 1'b1;
          state_d      = S_UPD_BULLET;
        end else begin
          state_d = S_UPD_ENEMY;
        end
      end
      S_UPD_BULLET: begin
        if (bullet_req_q && bullet_done) begin
          bullet_req_d = 1'b0;
          state_d      = S_CHECK;
        end else begin
          state_d = S_UPD_BULLET;
        end
      end
      S_CHECK: begin
        score_d = hit_enemy ? sat_inc8(score_q) : score_q;
        // Player death wins over the enemy-only respawn when both hit
        if (hit_player) begin
          if (life_q <= 3'd1) begin
            life_d      = 3'd0;
            game_over_d = 1'b1;
            state_d     = S_GAME_OVER;
          end else begin
            life_d    = life_q - 3'd1;
            respawn_d = 1'b1;
            cnt_d     = RESPAWN_INIT;
            state_d   = S_RESPAWN;
          end
        end else if (hit_enemy) begin
          enemy_respawn_d = 1'b1;
          state_d         = S_WAIT_FRAME;
        end else begin
          state_d = S_WAIT_FRAME;
        end
      end
      S_RESPAWN: begin
        if (cnt_q == 8'd0) begin
          state_d = S_WAIT_FRAME;
        end else if (frame_tick) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_GAME_OVER: begin
        if (restart) begin
          game_over_d = 1'b0;
          life_d      = LIFE_INIT;
          score_d     = 8'd0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_GAME_OVER;
        end
      end
      default: begin
        player_req_d = 1'b0;
        enemy_req_d  = 1'b0;
        bullet_req_d = 1'b0;
        state_d      = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      player_req_q    <= 1'b0;
      enemy_req_q     <= 1'b0;
      bullet_req_q    <= 1'b0;
      respawn_q       <= 1'b0;
      enemy_respawn_q <= 1'b0;
      life_q          <= LIFE_INIT;
      score_q         <= 8'd0;
      game_over_q     <= 1'b0;
      overrun_q       <= 1'b0;
      cnt_q           <= 8'd0;
    end else begin
      state_q         <= state_d;
      player_req_q    <= player_req_d;
      enemy_req_q     <= enemy_req_d;
      bullet_req_q    <= bullet_req_d;
      respawn_q       <= respawn_d;
      enemy_respawn_q <= enemy_respawn_d;
      life_q          <= life_d;
      score_q         <= score_d;
      game_over_q     <= game_over_d;
      overrun_q       <= overrun_d;
      cnt_q           <= cnt_d;
    end
  end

  assign player_req    = player_req_q;
  assign enemy_req     = enemy_req_q;
  assign bullet_req    = bullet_req_q;
  assign respawn       = respawn_q;
  assign enemy_respawn = enemy_respawn_q;
  assign life          = life_q;
  assign score         = score_q;
  assign game_over     = game_over_q;
  assign frame_overrun = overrun_q;
  assign state         = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: expected values are queued as stimulus is
// driven and compared against DUT outputs sampled 1ns after each rising edge.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, restart, frame_tick;
  logic       player_done, enemy_done, bullet_done, hit_player, hit_enemy;
  logic       player_req, enemy_req, bullet_req, respawn, enemy_respawn;
  logic       game_over, frame_overrun;
  logic [2:0] life, state;
  logic [7:0] score;

  int vectors     = 0;
  int miscompares = 0;
  int life_m      = 3;
  int score_m     = 0;

  localparam int O_ST = 0, O_LIFE = 1, O_SCORE = 2, O_GO = 3, O_OVR = 4;
  localparam int O_PREQ = 5, O_EREQ = 6, O_BREQ = 7, O_RSP = 8, O_ERSP = 9;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] val;
  } exp_t;
  exp_t sb[$];

  game_sequencer #(.LIVES_INIT(3), .RESPAWN_FRAMES(60)) dut (
    .clk(clk), .reset(reset), .start(start), .restart(restart),
    .frame_tick(frame_tick),
    .player_req(player_req), .player_done(player_done),
    .enemy_req(enemy_req), .enemy_done(enemy_done),
    .bullet_req(bullet_req), .bullet_done(bullet_done),
    .hit_player(hit_player), .hit_enemy(hit_enemy),
    .respawn(respawn), .enemy_respawn(enemy_respawn),
    .life(life), .score(score), .game_over(game_over),
    .frame_overrun(frame_overrun), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] obs(input int sel);
    case (sel)
      O_ST:    return {5'd0, state};
      O_LIFE:  return {5'd0, life};
      O_SCORE: return score;
      O_GO:    return {7'd0, game_over};
      O_OVR:   return {7'd0, frame_overrun};
      O_PREQ:  return {7'd0, player_req};
      O_EREQ:  return {7'd0, enemy_req};
      O_BREQ:  return {7'd0, bullet_req};
      O_RSP:   return {7'd0, respawn};
      O_ERSP:  return {7'd0, enemy_respawn};
      default: return 8'hEE;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input int sel, input logic [7:0] val);
    sb.push_back('{tag, sel, val});
  endtask

  task automatic drain();
    exp_t e;
    logic [7:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sel);
      vectors++;
      assert (o === e.val) else begin
        miscompares++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, o, e.val);
      end
    end
  endtask

  // One full frame: tick, three handshakes with given done delays, then CHECK
  task automatic frame(input int dp, input int de, input int db,
                       input bit hp, input bit he, input bit stray);
    int es, rs, ers, go;
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
    push("tick_state", O_ST, 8'd2); push("preq_rise", O_PREQ, 8'd1);
    push("ereq_idle", O_EREQ, 8'd0); drain();
    if (stray) begin enemy_done = 1'b1; bullet_done = 1'b1; end
    repeat (dp) begin
      cyc();
      push("preq_hold", O_PREQ, 8'd1); push("p_state", O_ST, 8'd2);
      push("stray_ignored", O_EREQ, 8'd0); drain();
    end
    enemy_done = 1'b0; bullet_done = 1'b0;
    player_done = 1'b1; cyc(); player_done = 1'b0;
    push("e_state", O_ST, 8'd3); push("preq_drop", O_PREQ, 8'd0);
    push("ereq_chain", O_EREQ, 8'd1); drain();
    repeat (de) begin
      cyc();
      push("ereq_hold", O_EREQ, 8'd1); push("breq_wait", O_BREQ, 8'd0); drain();
    end
    enemy_done = 1'b1; cyc(); enemy_done = 1'b0;
    push("b_state", O_ST, 8'd4); push("ereq_drop", O_EREQ, 8'd0);
    push("breq_chain", O_BREQ, 8'd1); drain();
    repeat (db) begin
      cyc();
      push("breq_hold", O_BREQ, 8'd1); drain();
    end
    bullet_done = 1'b1; cyc(); bullet_done = 1'b0;
    push("check_state", O_ST, 8'd5); push("breq_drop", O_BREQ, 8'd0); drain();
    hit_player = hp; hit_enemy = he; cyc(); hit_player = 1'b0; hit_enemy = 1'b0;
    if (he) score_m = (score_m == 255) ? 255 : score_m + 1;
    go = 0; rs = 0; ers = 0;
    if (hp) begin
      if (life_m == 1) begin life_m = 0; es = 7; go = 1; end
      else begin life_m = life_m - 1; es = 6; rs = 1; end
    end else begin
      es = 1; ers = he ? 1 : 0;
    end
    push("post_check_state", O_ST, 8'(es)); push("life", O_LIFE, 8'(life_m));
    push("score", O_SCORE, 8'(score_m)); push("respawn", O_RSP, 8'(rs));
    push("enemy_respawn", O_ERSP, 8'(ers)); push("game_over", O_GO, 8'(go));
    drain();
    cyc();
    push("respawn_pulse_end", O_RSP, 8'd0); push("erespawn_pulse_end", O_ERSP, 8'd0);
    drain();
  endtask

  // 60 ticks spent in RESPAWN, leaving on the cycle after the count reaches 0
  task automatic respawn_wait();
    for (int i = 1; i <= 60; i++) begin
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
      push("respawn_hold", O_ST, 8'd6); drain();
      cyc();
      push("respawn_exit", O_ST, (i == 60) ? 8'd1 : 8'd6); drain();
    end
    push("no_overrun_in_respawn", O_OVR, 8'd0); drain();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; restart = 1'b0; frame_tick = 1'b0;
    player_done = 1'b0; enemy_done = 1'b0; bullet_done = 1'b0;
    hit_player = 1'b0; hit_enemy = 1'b0;
    cyc(); cyc();
    push("rst_state", O_ST, 8'd0); push("rst_life", O_LIFE, 8'd3);
    push("rst_score", O_SCORE, 8'd0); push("rst_go", O_GO, 8'd0);
    push("rst_ovr", O_OVR, 8'd0); push("rst_preq", O_PREQ, 8'd0);
    push("rst_rsp", O_RSP, 8'd0); drain();

    reset = 1'b1; start = 1'b1; cyc(); start = 1'b0;
    push("start_state", O_ST, 8'd1); push("start_respawn", O_RSP, 8'd1);
    push("start_life", O_LIFE, 8'd3); push("start_score", O_SCORE, 8'd0); drain();
    cyc();
    push("start_respawn_end", O_RSP, 8'd0); push("wait_state", O_ST, 8'd1); drain();

    frame(2, 5, 0, 1'b0, 1'b0, 1'b1);
    frame(0, 1, 3, 1'b0, 1'b1, 1'b0);
    frame(1, 0, 0, 1'b1, 1'b0, 1'b0);
    respawn_wait();
    frame(0, 0, 1, 1'b1, 1'b1, 1'b0);
    respawn_wait();
    for (int k = 0; k < 256; k++) frame(0, 0, 0, 1'b0, 1'b1, 1'b0);
    push("score_saturated", O_SCORE, 8'd255); drain();
    frame(0, 0, 0, 1'b1, 1'b0, 1'b0);

    frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
    push("go_hold", O_ST, 8'd7); push("go_no_ovr", O_OVR, 8'd0);
    push("go_life_frozen", O_LIFE, 8'd0); push("go_score_frozen", O_SCORE, 8'd255);
    push("go_flag", O_GO, 8'd1); drain();
    restart = 1'b1; cyc(); restart = 1'b0;
    life_m = 3; score_m = 0;
    push("restart_state", O_ST, 8'd0); push("restart_life", O_LIFE, 8'(life_m));
    push("restart_score", O_SCORE, 8'(score_m)); push("restart_go", O_GO, 8'd0); drain();

    start = 1'b1; cyc(); start = 1'b0; cyc();
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
    push("ovr_pre_state", O_ST, 8'd2); push("ovr_pre", O_OVR, 8'd0); drain();
    frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
    push("ovr_set", O_OVR, 8'd1); push("ovr_state", O_ST, 8'd2);
    push("ovr_preq", O_PREQ, 8'd1); drain();
    cyc();
    push("ovr_sticky", O_OVR, 8'd1); drain();
    reset = 1'b0; cyc();
    push("midreq_rst_preq", O_PREQ, 8'd0); push("midreq_rst_state", O_ST, 8'd0);
    push("midreq_rst_ovr", O_OVR, 8'd0); drain();
    reset = 1'b1; player_done = 1'b1; cyc(); player_done = 1'b0;
    push("late_done_state", O_ST, 8'd0); push("late_done_ereq", O_EREQ, 8'd0); drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
